// File: rtl/manch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : manch_pkg
// Purpose  : Shared definitions for the Manchester frame receiver. Holds the
//            decode FSM state encoding, parity mode constants, err_code bit
//            indices and the half-bit length derivation.
// Revision : 1.0  initial release
// ============================================================================
package manch_pkg;

    // Decode FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_RECEIVE = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // err_code bit positions
    localparam int ERR_VIOL   = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_STOP   = 2;
    localparam int ERR_OVF    = 3;

    // Clock cycles per half Manchester cell
    function automatic int unsigned halfbit(input int unsigned clk_freq,
                                            input int unsigned baud);
        return clk_freq / (2 * baud);
    endfunction

endpackage
`default_nettype wire

// File: rtl/manch_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : manch_rx_fifo_if
// Purpose  : Output-side valid/ready bundle of the Manchester receiver.
//            out_valid  FIFO not empty
//            out_ready  consumer accepts the head word
//            out_data   FIFO head (first-word-fall-through)
//            fifo_level number of occupied entries
//            master: receiver side, slave: consumer side.
// Revision : 1.0  initial release
// ============================================================================
interface manch_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_BITS-1:0]            out_data;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level;

    modport master (output out_valid, output out_data, output fifo_level,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  fifo_level,
                    output out_ready);
endinterface
`default_nettype wire

// File: rtl/manch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : manch_sync_fifo
// Purpose  : Synchronous first-word-fall-through FIFO. DEPTH must be a power
//            of two so the pointers wrap naturally.
// Ports    : clk, reset (async, active low), push/wdata, pop, rdata (head,
//            0 when empty), full, empty, level.
// Revision : 1.0  initial release
// ============================================================================
module manch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH+1)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic      [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/manch_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : manch_rx_fifo
// Purpose  : Manchester UART-frame receiver ('1' = low->high, '0' = high->low)
//            with optional parity, per-frame error reporting and an output
//            FWFT FIFO. Frame: start '0', DATA_BITS data (MSB first), optional
//            parity, STOP_BITS stop '1's.
// Ports    : clk, reset (async, active low), rx (async line, idle high),
//            out_if (valid/ready FIFO output), err_pulse/err_code (rejected
//            frame), overflow_sticky/err_clr, busy (START or RECEIVE).
// Options  : MANCH_RESYNC_EN - realign the cell timer on each mid-cell edge
//            seen within +-HALFBIT/2 of its nominal time.
// Revision : 1.0  initial release
// ============================================================================
module manch_rx_fifo
    import manch_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int BAUDRATE    = 115200,
    parameter int CLK_FREQ    = 18_750_000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       rx,
    manch_rx_fifo_if.master out_if,
    output logic            err_pulse,
    output logic [3:0]      err_code,
    output logic            overflow_sticky,
    input  wire logic       err_clr,
    output logic            busy
);
    localparam logic [31:0] c_half    = 32'(halfbit(CLK_FREQ, BAUDRATE));
    localparam logic [31:0] c_quarter = c_half / 32'd2;
    localparam logic [31:0] c_sat     = (32'd3 * c_half) / 32'd2;
    localparam int          c_par     = (PARITY_MODE != PARITY_NONE) ? 1 : 0;
    localparam int          c_nbits   = DATA_BITS + c_par + STOP_BITS;

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [1:0]           r_state;
    logic [31:0]          r_hi_cnt;
    logic [31:0]          r_t;       // cycles since the start-cell mid-point
    logic [31:0]          r_target;  // t of the next A or B sample
    logic [31:0]          r_cell;
    logic                 r_phase;   // 0: waiting for A, 1: waiting for B
    logic                 r_a;
    logic                 r_viol;
    logic [c_nbits-1:0]   r_shift;

    logic                 w_line;
    logic                 w_fall;
    logic [DATA_BITS-1:0] w_data;
    logic                 w_par_err;
    logic                 w_stop_err;
    logic [3:0]           w_errs;
    logic                 w_is_check;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_overflow;
    logic                 w_push;
    logic                 w_reject;
    logic [3:0]           w_code;

    assign w_line = r_sync[1];
    assign w_fall = r_prev && !w_line;
    assign busy   = (r_state == ST_START) || (r_state == ST_RECEIVE);

    // Synchroniser; reset to the idle level so no edge is seen on release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_prev <= w_line;
        end
    end

    // Frame field extraction from the completed shift register
    assign w_data     = r_shift[c_nbits-1 -: DATA_BITS];
    assign w_stop_err = ~&r_shift[STOP_BITS-1:0];

    generate
        if (PARITY_MODE == PARITY_NONE) begin : g_no_parity
            assign w_par_err = 1'b0;
        end else begin : g_parity
            assign w_par_err = (^w_data) ^ r_shift[STOP_BITS]
                               ^ (PARITY_MODE == PARITY_ODD);
        end
    endgenerate

    always_comb begin
        w_errs             = 4'b0;
        w_errs[ERR_VIOL]   = r_viol;
        w_errs[ERR_PARITY] = w_par_err;
        w_errs[ERR_STOP]   = w_stop_err;
    end

    assign w_is_check = (r_state == ST_CHECK);
    assign w_pop      = out_if.out_valid && out_if.out_ready;
    assign w_overflow = w_is_check && (w_errs == 4'b0) && w_full && !w_pop;
    assign w_push     = w_is_check && (w_errs == 4'b0) && !w_overflow;
    assign w_reject   = w_is_check && ((w_errs != 4'b0) || w_overflow);
    assign w_code     = w_errs | (w_overflow ? (4'b1 << ERR_OVF) : 4'b0);

    manch_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (w_data),
        .pop   (out_if.out_ready),
        .rdata (out_if.out_data),
        .full  (w_full),
        .empty (w_empty),
        .level (out_if.fifo_level)
    );
    assign out_if.out_valid = !w_empty;

    // Decode FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_hi_cnt <= '0;
            r_t      <= '0;
            r_target <= '0;
            r_cell   <= '0;
            r_phase  <= 1'b0;
            r_a      <= 1'b0;
            r_viol   <= 1'b0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_line) begin
                        if (r_hi_cnt < c_sat) begin
                            r_hi_cnt <= r_hi_cnt + 32'd1;
                        end
                    end else begin
                        r_hi_cnt <= '0;
                    end
                    // The edge cycle itself is t=0
                    if (w_fall && (r_hi_cnt == c_sat)) begin
                        r_state <= ST_START;
                        r_t     <= 32'd1;
                    end
                end
                ST_START: begin
                    r_t <= r_t + 32'd1;
                    if (r_t == c_quarter) begin
                        if (!w_line) begin
                            r_state  <= ST_RECEIVE;
                            r_target <= c_half + c_quarter;
                            r_cell   <= 32'd1;
                            r_phase  <= 1'b0;
                            r_viol   <= 1'b0;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_RECEIVE: begin
`ifdef MANCH_RESYNC_EN
                    // Between A and B of a cell the only legal edge is the
                    // mid-cell one; snap t to its nominal value 2k*HALFBIT.
                    if (r_phase && (r_prev != w_line) && (r_t != r_target)) begin
                        r_t <= r_target - c_quarter + 32'd1;
                    end else begin
                        r_t <= r_t + 32'd1;
                    end
`else
                    r_t <= r_t + 32'd1;
`endif
                    if (r_t == r_target) begin
                        r_target <= r_target + c_half;
                        r_phase  <= !r_phase;
                        if (!r_phase) begin
                            r_a <= w_line;
                        end else begin
                            r_shift <= {r_shift[c_nbits-2:0], w_line};
                            if (r_a == w_line) begin
                                r_viol <= 1'b1;
                            end
                            if (r_cell == 32'(c_nbits)) begin
                                r_state <= ST_CHECK;
                            end else begin
                                r_cell <= r_cell + 32'd1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    // The trailing stop half counts as idle so frames may
                    // follow each other with no gap.
                    r_hi_cnt <= w_line ? c_sat : '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Error reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_pulse       <= 1'b0;
            err_code        <= 4'b0;
            overflow_sticky <= 1'b0;
        end else begin
            err_pulse <= w_reject;
            err_code  <= w_reject ? w_code : 4'b0;
            if (err_clr) begin
                overflow_sticky <= 1'b0;
            end else if (w_overflow) begin
                overflow_sticky <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
